pe_window_sequencer: RTL and testbench

- Per-PE command sequencer that drives the 8-bit control word, offset value and MAC strobes of a PE's local-store controller (kernel FSM plus neuron FSM).
- On `start` it loads the four row/column offsets, then sweeps a kRows x kCols convolution window `passes` times, accumulating across passes.
- It signals the accumulator to clear at the start of a run and reports when the result is valid.
- It sits between the array-level scheduler and each PE.

---
 rtl/pe_window_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_pe_window_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_window_sequencer.sv
// pe_window_sequencer: per-PE command sequencer for the local-store controller.
// On start it loads the kernel/neuron row/column offsets (four SET commands).
// It then sweeps a kRows x kCols window `passes` times back to back, raising
// MAC strobes, and ends with a one-cycle FIN that pulses done/accValid.
// Every output is registered from the state being entered, so a command is
// stable for the whole cycle and in place for the store's falling-edge action.
// Optional feature macro: LSC_LOAD_MODE_EN. It adds the loadMode input and the
// loadStrobe output, which turn the sweep into a kernel-store load.
module pe_window_sequencer #(
    parameter int depth = 2,
    parameter int KW    = 4,
    parameter int PW    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             stall,
    input  logic [KW-1:0]    kRows,
    input  logic [KW-1:0]    kCols,
    input  logic [PW-1:0]    passes,
    input  logic [depth-1:0] kRowOfst,
    input  logic [depth-1:0] kColOfst,
    input  logic [depth-1:0] nRowOfst,
    input  logic [depth-1:0] nColOfst,
`ifdef LSC_LOAD_MODE_EN
    input  logic             loadMode,
    output logic             loadStrobe,
`endif
    output logic [7:0]       controlSignal,
    output logic [depth-1:0] initSettings,
    output logic             macEn,
    output logic             accClear,
    output logic             accValid,
    output logic             busy,
    output logic             done
);

    // Command words: {kernelCtrl, kernelWrite, neuronCtrl, neuronWrite}.
    localparam logic [7:0] CMD_INIT      = 8'h00;
    localparam logic [7:0] CMD_HOLD      = 8'h22;
    localparam logic [7:0] CMD_INCR      = 8'h44;
    localparam logic [7:0] CMD_JUMP      = 8'h66;
    localparam logic [7:0] CMD_SET_K_ROW = 8'h88;
    localparam logic [7:0] CMD_SET_K_COL = 8'hAA;
    localparam logic [7:0] CMD_SET_N_ROW = 8'hCC;
    localparam logic [7:0] CMD_SET_N_COL = 8'hEE;
    localparam logic [7:0] KWRITE_BIT    = 8'h10;

    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] P_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        CFG_KR,
        CFG_KC,
        CFG_NR,
        CFG_NC,
        SWEEP,
        FIN
    } state_t;

    state_t           r_state, w_state_nxt;

    // Run configuration captured at start.
    logic [KW-1:0]    r_k_rows, r_k_cols;
    logic [PW-1:0]    r_passes;
    logic [depth-1:0] r_k_col_ofst, r_n_row_ofst, r_n_col_ofst;
    logic             r_load;

    // Position of the element currently presented during SWEEP.
    logic [KW-1:0]    r_col, r_row, w_col_nxt, w_row_nxt;
    logic [PW-1:0]    r_pass, w_pass_nxt;

    // Registered outputs and their next values.
    logic [7:0]       r_ctrl, w_ctrl_nxt;
    logic [depth-1:0] r_init, w_init_nxt;
    logic             r_mac, r_clear, r_valid, r_busy, r_done;
    logic             w_clear_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;
    logic             w_sweep_nxt;

    logic             w_load_in;
    logic             w_zero_cfg;
    logic             w_frozen;
    logic             w_col_wrap, w_row_wrap, w_last;

`ifdef LSC_LOAD_MODE_EN
    assign w_load_in = loadMode;
`else
    assign w_load_in = 1'b0;
`endif

    // A zero dimension or pass count skips straight to FIN; a load run always
    // makes exactly one pass, so its pass count cannot be zero.
    assign w_zero_cfg = (kRows == '0) || (kCols == '0) ||
                        ((passes == '0) && !w_load_in);

    // Stall only freezes the configuration and sweep phases.
    assign w_frozen = stall && (r_state inside {CFG_KR, CFG_KC, CFG_NR, CFG_NC, SWEEP});

    assign w_col_wrap = (r_col == r_k_cols - K_ONE);
    assign w_row_wrap = (r_row == r_k_rows - K_ONE);
    assign w_last     = w_col_wrap && w_row_wrap && (r_pass == r_passes - P_ONE);

    // INIT at the window origin, JUMP at the start of each later row, INCR
    // otherwise; a load run walks the store linearly and sets kernelWrite.
    function automatic logic [7:0] sweep_cmd(input logic [KW-1:0] col,
                                             input logic [KW-1:0] row,
                                             input logic          load);
        logic [7:0] cmd;
        if ((col == '0) && (row == '0))
            cmd = CMD_INIT;
        else if ((col == '0) && !load)
            cmd = CMD_JUMP;
        else
            cmd = CMD_INCR;
        return load ? (cmd | KWRITE_BIT) : cmd;
    endfunction

    // Next state, next counters and the outputs for the state being entered.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pass_nxt  = r_pass;
        w_ctrl_nxt  = CMD_HOLD;
        w_init_nxt  = '0;
        w_sweep_nxt = 1'b0;
        w_clear_nxt = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (w_frozen) begin
            w_busy_nxt = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_busy_nxt = 1'b1;
                        if (w_zero_cfg) begin
                            w_state_nxt = FIN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = CFG_KR;
                            w_ctrl_nxt  = CMD_SET_K_ROW;
                            w_init_nxt  = kRowOfst;
                        end
                    end
                end
                CFG_KR: begin
                    w_state_nxt = CFG_KC;
                    w_ctrl_nxt  = CMD_SET_K_COL;
                    w_init_nxt  = r_k_col_ofst;
                    w_busy_nxt  = 1'b1;
                end
                CFG_KC: begin
                    w_state_nxt = CFG_NR;
                    w_ctrl_nxt  = CMD_SET_N_ROW;
                    w_init_nxt  = r_n_row_ofst;
                    w_busy_nxt  = 1'b1;
                end
                CFG_NR: begin
                    w_state_nxt = CFG_NC;
                    w_ctrl_nxt  = CMD_SET_N_COL;
                    w_init_nxt  = r_n_col_ofst;
                    w_busy_nxt  = 1'b1;
                end
                CFG_NC: begin
                    w_state_nxt = SWEEP;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_pass_nxt  = '0;
                    w_ctrl_nxt  = sweep_cmd('0, '0, r_load);
                    w_sweep_nxt = 1'b1;
                    w_clear_nxt = !r_load;
                    w_busy_nxt  = 1'b1;
                end
                SWEEP: begin
                    w_busy_nxt = 1'b1;
                    if (w_last) begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = !r_load;
                    end else begin
                        w_col_nxt = w_col_wrap ? '0 : r_col + K_ONE;
                        if (w_col_wrap)
                            w_row_nxt = w_row_wrap ? '0 : r_row + K_ONE;
                        if (w_col_wrap && w_row_wrap)
                            w_pass_nxt = r_pass + P_ONE;
                        w_ctrl_nxt  = sweep_cmd(w_col_nxt, w_row_nxt, r_load);
                        w_sweep_nxt = 1'b1;
                    end
                end
                FIN: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_pass  <= '0;
            r_ctrl  <= CMD_HOLD;
            r_init  <= '0;
            r_mac   <= 1'b0;
            r_clear <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_pass  <= w_pass_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_init  <= w_init_nxt;
            r_mac   <= w_sweep_nxt && !r_load;
            r_clear <= w_clear_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Capture the run configuration when a start is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_k_rows     <= '0;
            r_k_cols     <= '0;
            r_passes     <= '0;
            r_k_col_ofst <= '0;
            r_n_row_ofst <= '0;
            r_n_col_ofst <= '0;
            r_load       <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_k_rows     <= kRows;
            r_k_cols     <= kCols;
            r_passes     <= w_load_in ? P_ONE : passes;
            r_k_col_ofst <= kColOfst;
            r_n_row_ofst <= nRowOfst;
            r_n_col_ofst <= nColOfst;
            r_load       <= w_load_in;
        end
    end

`ifdef LSC_LOAD_MODE_EN
    logic r_strobe;

    // Load strobe accompanies every sweep cycle of a load run.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_strobe <= 1'b0;
        else
            r_strobe <= w_sweep_nxt && r_load;
    end

    assign loadStrobe = r_strobe;
`endif

    assign controlSignal = r_ctrl;
    assign initSettings  = r_init;
    assign macEn         = r_mac;
    assign accClear      = r_clear;
    assign accValid      = r_valid;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_pe_window_sequencer.sv
// Testbench for pe_window_sequencer. A small reference model pushes the
// expected per-cycle outputs of a run into a queue; the run driver pops one
// entry per cycle and compares it with the DUT outputs sampled on the falling
// edge.
module tb_pe_window_sequencer;

    localparam int DEPTH = 2;
    localparam int KW    = 4;
    localparam int PW    = 8;

    logic             CLK;
    logic             RST_N;
    logic             start;
    logic             stall;
    logic [KW-1:0]    kRows, kCols;
    logic [PW-1:0]    passes;
    logic [DEPTH-1:0] kRowOfst, kColOfst, nRowOfst, nColOfst;
    logic [7:0]       controlSignal;
    logic [DEPTH-1:0] initSettings;
    logic             macEn, accClear, accValid, busy, done;
`ifdef LSC_LOAD_MODE_EN
    logic             loadMode;
    logic             loadStrobe;
`endif

    typedef struct packed {
        logic [7:0]       ctrl;
        logic [DEPTH-1:0] init;
        logic             mac;
        logic             clear;
        logic             valid;
        logic             busy;
        logic             done;
        logic             strobe;
        logic             drv_stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    pe_window_sequencer #(.depth(DEPTH), .KW(KW), .PW(PW)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .start         (start),
        .stall         (stall),
        .kRows         (kRows),
        .kCols         (kCols),
        .passes        (passes),
        .kRowOfst      (kRowOfst),
        .kColOfst      (kColOfst),
        .nRowOfst      (nRowOfst),
        .nColOfst      (nColOfst),
`ifdef LSC_LOAD_MODE_EN
        .loadMode      (loadMode),
        .loadStrobe    (loadStrobe),
`endif
        .controlSignal (controlSignal),
        .initSettings  (initSettings),
        .macEn         (macEn),
        .accClear      (accClear),
        .accValid      (accValid),
        .busy          (busy),
        .done          (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e      = '0;
        e.ctrl = 8'h22;
        return e;
    endfunction

    // Current DUT outputs packed like an expectation (drv_stall excluded).
    function automatic exp_t observe();
        exp_t o;
        o        = '0;
        o.ctrl   = controlSignal;
        o.init   = initSettings;
        o.mac    = macEn;
        o.clear  = accClear;
        o.valid  = accValid;
        o.busy   = busy;
        o.done   = done;
`ifdef LSC_LOAD_MODE_EN
        o.strobe = loadStrobe;
`endif
        return o;
    endfunction

    task automatic set_cfg(input int kr, input int kc, input int ps,
                           input int o0, input int o1, input int o2, input int o3,
                           input bit load);
        kRows    = KW'(kr);
        kCols    = KW'(kc);
        passes   = PW'(ps);
        kRowOfst = DEPTH'(o0);
        kColOfst = DEPTH'(o1);
        nRowOfst = DEPTH'(o2);
        nColOfst = DEPTH'(o3);
`ifdef LSC_LOAD_MODE_EN
        loadMode = load;
`else
        if (load) $display("note: load mode requested in a build without it");
`endif
    endtask

    // Reference model: expected output sequence of one run, from the cycle
    // after start through the first IDLE cycle. stall_at is the global sweep
    // element index that gets stall_len hold cycles in front of it.
    task automatic push_run(input int kr, input int kc, input int ps,
                            input int o0, input int o1, input int o2, input int o3,
                            input int stall_at, input int stall_len, input bit load);
        exp_t e;
        int   eff_ps;
        int   n;
        int   k;
        int   ofs[4];
        logic [7:0] set_codes[4];
        set_codes[0] = 8'h88; set_codes[1] = 8'hAA;
        set_codes[2] = 8'hCC; set_codes[3] = 8'hEE;
        ofs[0] = o0; ofs[1] = o1; ofs[2] = o2; ofs[3] = o3;
        eff_ps = load ? 1 : ps;
        if (kr == 0 || kc == 0 || eff_ps == 0) begin
            e      = idle_exp();
            e.busy = 1'b1;
            e.done = 1'b1;
            sb_q.push_back(e);
        end else begin
            for (int c = 0; c < 4; c++) begin
                e      = idle_exp();
                e.ctrl = set_codes[c];
                e.init = DEPTH'(ofs[c]);
                e.busy = 1'b1;
                sb_q.push_back(e);
            end
            n = kr * kc;
            k = 0;
            for (int p = 0; p < eff_ps; p++) begin
                for (int el = 0; el < n; el++) begin
                    if (k == stall_at) begin
                        for (int s = 0; s < stall_len; s++) begin
                            e           = idle_exp();
                            e.busy      = 1'b1;
                            e.drv_stall = 1'b1;
                            sb_q.push_back(e);
                        end
                    end
                    e      = idle_exp();
                    e.busy = 1'b1;
                    if (el == 0)
                        e.ctrl = 8'h00;
                    else if ((el % kc) == 0 && !load)
                        e.ctrl = 8'h66;
                    else
                        e.ctrl = 8'h44;
                    if (load) begin
                        e.ctrl   = e.ctrl | 8'h10;
                        e.strobe = 1'b1;
                    end else begin
                        e.mac = 1'b1;
                    end
                    e.clear = !load && (p == 0) && (el == 0);
                    sb_q.push_back(e);
                    k++;
                end
            end
            e       = idle_exp();
            e.busy  = 1'b1;
            e.done  = 1'b1;
            e.valid = !load;
            sb_q.push_back(e);
        end
        sb_q.push_back(idle_exp());
    endtask

    // Issue start at a falling edge and compare up to max_items cycles of
    // output against the queue. Returns the number of busy cycles observed.
    task automatic run_seq(input string name, input int max_items, output int busy_seen);
        exp_t e;
        exp_t o;
        int   i;
        i         = 0;
        busy_seen = 0;
        start     = 1'b1;
        while (sb_q.size() > 0 && i < max_items) begin
            stall = sb_q[0].drv_stall;
            @(posedge CLK);
            #1;
            start = 1'b0;
            @(negedge CLK);
            e = sb_q.pop_front();
            e.drv_stall = 1'b0;
            o = observe();
            n_checks++;
            if (o !== e)
                $display("FAIL %s[%0d] got ctrl=%h init=%0d mac=%b clr=%b val=%b busy=%b done=%b strb=%b exp ctrl=%h init=%0d mac=%b clr=%b val=%b busy=%b done=%b strb=%b",
                         name, i, o.ctrl, o.init, o.mac, o.clear, o.valid, o.busy, o.done, o.strobe,
                         e.ctrl, e.init, e.mac, e.clear, e.valid, e.busy, e.done, e.strobe);
            else
                n_passed++;
            if (busy === 1'b1) busy_seen++;
            i++;
        end
        stall = 1'b0;
    endtask

    task automatic test_reset;
        exp_t o;
        RST_N = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 1'b0);
        #12;
        o = observe();
        n_checks++;
        if (o !== idle_exp())
            $display("FAIL reset_hold got ctrl=%h busy=%b done=%b mac=%b exp ctrl=22 all zero",
                     o.ctrl, o.busy, o.done, o.mac);
        else
            n_passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        o = observe();
        n_checks++;
        if (o !== idle_exp())
            $display("FAIL reset_idle got ctrl=%h busy=%b done=%b mac=%b exp ctrl=22 all zero",
                     o.ctrl, o.busy, o.done, o.mac);
        else
            n_passed++;
    endtask

    task automatic test_single_pass;
        int b;
        set_cfg(2, 3, 1, 1, 2, 3, 0, 1'b0);
        push_run(2, 3, 1, 1, 2, 3, 0, -1, 0, 1'b0);
        run_seq("single_pass", 1000, b);
        n_checks++;
        if (b !== 4 + 6 + 1)
            $display("FAIL single_pass_busy got %0d exp %0d", b, 11);
        else
            n_passed++;
    endtask

    task automatic test_multi_pass;
        int b;
        @(negedge CLK);
        set_cfg(2, 2, 3, 3, 1, 0, 2, 1'b0);
        push_run(2, 2, 3, 3, 1, 0, 2, -1, 0, 1'b0);
        run_seq("multi_pass", 1000, b);
        n_checks++;
        if (b !== 17)
            $display("FAIL multi_pass_busy got %0d exp %0d", b, 17);
        else
            n_passed++;
    endtask

    task automatic test_stall;
        int b;
        @(negedge CLK);
        set_cfg(2, 3, 1, 1, 2, 3, 0, 1'b0);
        push_run(2, 3, 1, 1, 2, 3, 0, 3, 2, 1'b0);
        run_seq("stall", 1000, b);
        n_checks++;
        if (b !== 4 + 6 + 1 + 2)
            $display("FAIL stall_busy got %0d exp %0d", b, 13);
        else
            n_passed++;
    endtask

    task automatic test_zero_config;
        int b;
        @(negedge CLK);
        set_cfg(3, 0, 2, 1, 1, 1, 1, 1'b0);
        push_run(3, 0, 2, 1, 1, 1, 1, -1, 0, 1'b0);
        run_seq("zero_cfg", 1000, b);
        n_checks++;
        if (b !== 1)
            $display("FAIL zero_cfg_busy got %0d exp %0d", b, 1);
        else
            n_passed++;
    endtask

    task automatic test_reset_mid_run;
        int   b;
        exp_t o;
        @(negedge CLK);
        set_cfg(2, 3, 1, 1, 2, 3, 0, 1'b0);
        push_run(2, 3, 1, 1, 2, 3, 0, -1, 0, 1'b0);
        run_seq("abort_prefix", 7, b);
        sb_q.delete();
        #2;
        RST_N = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if (o !== idle_exp())
            $display("FAIL abort_async got ctrl=%h busy=%b mac=%b done=%b exp ctrl=22 all zero",
                     o.ctrl, o.busy, o.mac, o.done);
        else
            n_passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_checks++;
            if ({done, accValid, busy} !== 3'b000)
                $display("FAIL abort_quiet[%0d] got done=%b accValid=%b busy=%b exp 0 0 0",
                         c, done, accValid, busy);
            else
                n_passed++;
        end
        push_run(2, 3, 1, 1, 2, 3, 0, -1, 0, 1'b0);
        run_seq("after_abort", 1000, b);
    endtask

`ifdef LSC_LOAD_MODE_EN
    task automatic test_load_mode;
        int b;
        @(negedge CLK);
        set_cfg(2, 2, 5, 2, 3, 1, 0, 1'b1);
        push_run(2, 2, 5, 2, 3, 1, 0, -1, 0, 1'b1);
        run_seq("load_mode", 1000, b);
        n_checks++;
        if (b !== 4 + 4 + 1)
            $display("FAIL load_mode_busy got %0d exp %0d", b, 9);
        else
            n_passed++;
        loadMode = 1'b0;
    endtask
`endif

    initial begin
`ifdef LSC_LOAD_MODE_EN
        loadMode = 1'b0;
`endif
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_stall();
        test_zero_config();
        test_reset_mid_run();
`ifdef LSC_LOAD_MODE_EN
        test_load_mode();
`endif
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
